pc_trap_ctrl: RTL

Multi-cycle PC sequencer and trap controller for the ysyx_24090012 NPC core.
- Owns the architectural PC and issues fetch requests to the IFU over a valid/ready handshake.
- Accepts completion results from the EXU over a valid/ready handshake.
- Sequences ecall, exception, mret and ebreak handling through a single CSR write port.
- Adds parametrised width and reset vector, misaligned-target trapping, a retire counter and a generic exception input.

---
 rtl/npc_pkg.sv | 50 +++++
 rtl/pc_trap_ctrl_if.sv | 41 ++++
 rtl/retire_counter.sv | 22 ++
 rtl/pc_trap_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared types, CSR addresses, cause codes and mstatus helpers for the NPC PC/trap sequencer.
// No logic of its own; the mstatus helpers are pure combinational functions.
// Backpressure: not applicable.
package npc_pkg;

  typedef enum logic [2:0] {
    FETCH,
    EXEC,
    TRAP_EPC,
    TRAP_CAUSE,
    TRAP_STATUS,
    MRET_STATUS,
    HALT
  } state_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int CAUSE_INST_MISALIGNED = 0;
  localparam int CAUSE_ECALL_M         = 11;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  // Only the low bits of mstatus are touched; upper bits pass through untouched.
  localparam int MSTATUS_LOW_W  = 13;

  // Trap entry: stash MIE into MPIE, disable interrupts, record M-mode as previous privilege.
  function automatic logic [MSTATUS_LOW_W-1:0] mstatus_trap_entry(input logic [MSTATUS_LOW_W-1:0] s);
    logic [MSTATUS_LOW_W-1:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE] = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // mret: restore MIE from MPIE, set MPIE, drop previous privilege to U.
  function automatic logic [MSTATUS_LOW_W-1:0] mstatus_mret(input logic [MSTATUS_LOW_W-1:0] s);
    logic [MSTATUS_LOW_W-1:0] r;
    r = s;
    r[MSTATUS_MIE] = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
    return r;
  endfunction

endpackage

// File: rtl/pc_trap_ctrl_if.sv
// Bundles the IFU fetch handshake, EXU result handshake, CSR read values and CSR write port.
// No latency; pure wiring.
// Backpressure: ifu_ready stalls fetch, exu_valid gates execution completion.
interface pc_trap_ctrl_if #(
  parameter int XLEN    = 32,
  parameter int CAUSE_W = 5
);

  logic               ifu_valid;
  logic               ifu_ready;
  logic               exu_ready;
  logic               exu_valid;
  logic [XLEN-1:0]    exu_next_pc;
  logic               exu_is_ecall;
  logic               exu_is_mret;
  logic               exu_is_ebreak;
  logic               exu_exc_valid;
  logic [CAUSE_W-1:0] exu_exc_cause;
  logic [XLEN-1:0]    a0_data;
  logic [XLEN-1:0]    csr_mtvec;
  logic [XLEN-1:0]    csr_mepc;
  logic [XLEN-1:0]    csr_mstatus;
  logic               csr_wen;
  logic [11:0]        csr_waddr;
  logic [XLEN-1:0]    csr_wdata;

  // Controller side.
  modport master (
    output ifu_valid, exu_ready, csr_wen, csr_waddr, csr_wdata,
    input  ifu_ready, exu_valid, exu_next_pc, exu_is_ecall, exu_is_mret, exu_is_ebreak,
    input  exu_exc_valid, exu_exc_cause, a0_data, csr_mtvec, csr_mepc, csr_mstatus
  );

  // IFU / EXU / CSR-file side.
  modport slave (
    input  ifu_valid, exu_ready, csr_wen, csr_waddr, csr_wdata,
    output ifu_ready, exu_valid, exu_next_pc, exu_is_ecall, exu_is_mret, exu_is_ebreak,
    output exu_exc_valid, exu_exc_cause, a0_data, csr_mtvec, csr_mepc, csr_mstatus
  );

endinterface

// File: rtl/retire_counter.sv
// Free-running retired-instruction counter, wraps silently modulo 2^CNT_W.
// Latency: count reflects an inc pulse one cycle later.
// Backpressure: none.
module retire_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count one per retire pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_trap_ctrl.sv
// Architectural PC sequencer with ecall/exception/mret/ebreak handling through one CSR write port.
// Latency: normal insn >= 2 cycles, trap EXEC + 3 CSR cycles, mret EXEC + 1 cycle.
// Backpressure: holds pc/ifu_valid until ifu_ready; waits in EXEC until exu_valid.
module pc_trap_ctrl
  import npc_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h8000_0000,
  parameter int              CAUSE_W     = 5,
  parameter int              ECALL_CAUSE = CAUSE_ECALL_M,
  parameter int              CNT_W       = 64,
  parameter bit              IALIGN_CHK  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  pc_trap_ctrl_if.master    bus,
  output logic [XLEN-1:0]   pc,
  output logic              retire,
  output logic [CNT_W-1:0]  instret,
  output logic              halt,
  output logic [XLEN-1:0]   exit_code
);

  state_t              state;
  logic [XLEN-1:0]     cause_q;
  logic [CAUSE_W-1:0]  exc_cause;
  logic                misaligned;
  logic [XLEN-1:0]     mtvec_base;
  logic [XLEN-1:MSTATUS_LOW_W] ms_hi;
  logic [MSTATUS_LOW_W-1:0]    ms_lo;
  logic                unused_mtvec_lo;

  assign exc_cause       = bus.exu_exc_cause;
  assign misaligned      = IALIGN_CHK && (bus.exu_next_pc[1:0] != 2'b00);
  // Vectored mode is not supported; the mode bits are simply masked off.
  assign mtvec_base      = {bus.csr_mtvec[XLEN-1:2], 2'b00};
  assign unused_mtvec_lo = ^bus.csr_mtvec[1:0];
  assign ms_hi           = bus.csr_mstatus[XLEN-1:MSTATUS_LOW_W];
  assign ms_lo           = bus.csr_mstatus[MSTATUS_LOW_W-1:0];

  // Main sequencer: state, pc, handshake outputs, halt/exit latch and trap cause.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= FETCH;
      pc            <= RESET_PC;
      bus.ifu_valid <= 1'b0;
      bus.exu_ready <= 1'b0;
      retire        <= 1'b0;
      halt          <= 1'b0;
      exit_code     <= '0;
      cause_q       <= '0;
    end else begin
      retire <= 1'b0;
      case (state)
        FETCH: begin
          // ifu_valid is low only in the first cycle out of reset.
          if (!bus.ifu_valid) begin
            bus.ifu_valid <= 1'b1;
          end else if (bus.ifu_ready) begin
            bus.ifu_valid <= 1'b0;
            bus.exu_ready <= 1'b1;
            state         <= EXEC;
          end
        end
        EXEC: begin
          if (bus.exu_valid) begin
            bus.exu_ready <= 1'b0;
            if (bus.exu_is_ebreak) begin
              exit_code <= bus.a0_data;
              halt      <= 1'b1;
              state     <= HALT;
            end else if (bus.exu_exc_valid) begin
              cause_q <= XLEN'(exc_cause);
              state   <= TRAP_EPC;
            end else if (bus.exu_is_ecall) begin
              cause_q <= XLEN'(ECALL_CAUSE);
              state   <= TRAP_EPC;
            end else if (bus.exu_is_mret) begin
              state <= MRET_STATUS;
            end else if (misaligned) begin
              cause_q <= XLEN'(CAUSE_INST_MISALIGNED);
              state   <= TRAP_EPC;
            end else begin
              pc            <= bus.exu_next_pc;
              retire        <= 1'b1;
              bus.ifu_valid <= 1'b1;
              state         <= FETCH;
            end
          end
        end
        TRAP_EPC: state <= TRAP_CAUSE;
        TRAP_CAUSE: state <= TRAP_STATUS;
        TRAP_STATUS: begin
          // The trapping instruction does not retire.
          pc            <= mtvec_base;
          bus.ifu_valid <= 1'b1;
          state         <= FETCH;
        end
        MRET_STATUS: begin
          pc            <= bus.csr_mepc;
          retire        <= 1'b1;
          bus.ifu_valid <= 1'b1;
          state         <= FETCH;
        end
        HALT: state <= HALT;
        default: begin
          bus.ifu_valid <= 1'b0;
          bus.exu_ready <= 1'b0;
          state         <= FETCH;
        end
      endcase
    end
  end

  // CSR write port decoded straight from the state so reset kills a write at once.
  always_comb begin
    bus.csr_wen   = 1'b0;
    bus.csr_waddr = '0;
    bus.csr_wdata = '0;
    case (state)
      TRAP_EPC: begin
        bus.csr_wen   = 1'b1;
        bus.csr_waddr = CSR_MEPC;
        bus.csr_wdata = pc;
      end
      TRAP_CAUSE: begin
        bus.csr_wen   = 1'b1;
        bus.csr_waddr = CSR_MCAUSE;
        bus.csr_wdata = cause_q;
      end
      TRAP_STATUS: begin
        bus.csr_wen   = 1'b1;
        bus.csr_waddr = CSR_MSTATUS;
        bus.csr_wdata = {ms_hi, mstatus_trap_entry(ms_lo)};
      end
      MRET_STATUS: begin
        bus.csr_wen   = 1'b1;
        bus.csr_waddr = CSR_MSTATUS;
        bus.csr_wdata = {ms_hi, mstatus_mret(ms_lo)};
      end
      default: ;
    endcase
  end

  retire_counter #(
    .CNT_W(CNT_W)
  ) u_retire_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (retire),
    .count(instret)
  );

endmodule
